// File: rtl/l2norm_pkg.sv
// Shared types and helpers for the L2-norm AXI-Stream engine.
// Saturating add works on a fixed wide container so any ACC_W up to MAX_W can use it.
package l2norm_pkg;

    localparam int unsigned DEF_LANES  = 8;
    localparam int unsigned DEF_ELEM_W = 8;
    localparam int unsigned DEF_ACC_W  = 32;
    localparam int unsigned MAX_W      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } eng_state_e;

    // Carry out of a w-bit unsigned add of a and b.
    function automatic logic sat_carry(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int unsigned w);
        logic [MAX_W:0] full;
        full = {1'b0, a} + {1'b0, b};
        return |(full >> w);
    endfunction

    // w-bit unsigned add clamped to 2^w-1 on carry-out.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned w);
        logic [MAX_W:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (|(full >> w)) begin
            return {MAX_W{1'b1}} >> (MAX_W - w);
        end
        return full[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Restoring bit-pair integer square root, one result bit per cycle.
// done_c_o is high during the cycle whose edge completes the last iteration.
module isqrt_seq #(
    parameter int unsigned W = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start_i,
    input  logic [W-1:0]   op_i,
    output logic           busy_o,
    output logic           done_c_o,
    output logic [W/2-1:0] root_o
);
    localparam int unsigned ITER  = W / 2;
    localparam int unsigned CNT_W = $clog2(ITER);

    logic [W-1:0]      op_q, op_d;
    logic [ITER-1:0]   rem_q, rem_d;
    logic [ITER-1:0]   root_q, root_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [ITER+1:0]   rem_sh;
    logic [ITER+1:0]   trial;
    logic              fits;

    // Intermediate remainders stay below 2^ITER, so the narrow rem_q loses nothing that is reused.
    assign rem_sh   = {rem_q, op_q[W-1 -: 2]};
    assign trial    = {root_q, 2'b01};
    assign fits     = rem_sh >= trial;
    assign done_c_o = busy_q && (cnt_q == CNT_W'(ITER - 1));
    assign busy_o   = busy_q;
    assign root_o   = root_q;

    always_comb begin
        op_d   = op_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            op_d   = op_i;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            op_d   = {op_q[W-3:0], 2'b00};
            rem_d  = fits ? ITER'(rem_sh - trial) : ITER'(rem_sh);
            root_d = {root_q[ITER-2:0], fits};
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = !done_c_o;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/l2_norm_axis_param.sv
// Streams LANES-wide beats, accumulates squares of kept lanes until tlast, then emits
// floor(sqrt(sum)) or the raw sum; the sqrt runs while the next vector accumulates.
module l2_norm_axis_param
    import l2norm_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned ELEM_W = DEF_ELEM_W,
    parameter bit          SIGNED = 1'b1,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [LANES*ELEM_W-1:0] io_in_tdata,
    input  logic                    io_in_tvalid,
    input  logic [LANES-1:0]        io_in_tkeep,
    input  logic                    io_in_tlast,
    output logic                    io_in_tready,
    input  logic                    io_mode,
    output logic [ACC_W-1:0]        io_out_tdata,
    output logic                    io_out_tvalid,
    output logic                    io_out_tuser,
    output logic [ACC_W/8-1:0]      io_out_tkeep,
    output logic                    io_out_tlast,
    input  logic                    io_out_tready
);
    localparam int unsigned PROD_W = 2 * ELEM_W;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
    localparam int unsigned ITER   = ACC_W / 2;

    eng_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] eng_sum_q, eng_sum_d;
    logic             eng_mode_q, eng_mode_d;
    logic             eng_ovf_q, eng_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_user_q, out_user_d;

    logic [SUM_W-1:0] beat_sum;
    logic [ACC_W-1:0] acc_sum;
    logic             acc_carry;
    logic             in_accept;
    logic             xfer;
    logic             sq_start;
    logic             sq_busy;
    logic             sq_done_c;
    logic [ITER-1:0]  sq_root;

    // Exact per-beat sum of squares; a negative element is squared through its magnitude.
    always_comb begin
        logic [ELEM_W-1:0] elem;
        logic [ELEM_W-1:0] mag;
        logic [PROD_W-1:0] sq;
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            elem = io_in_tdata[i*ELEM_W +: ELEM_W];
            mag  = (SIGNED && elem[ELEM_W-1]) ? -elem : elem;
            sq   = PROD_W'(mag) * PROD_W'(mag);
            if (io_in_tkeep[i]) begin
                beat_sum = beat_sum + SUM_W'(sq);
            end
        end
    end

    assign io_in_tready = !(io_in_tlast && state_q != IDLE);
    assign in_accept    = io_in_tvalid && io_in_tready;
    assign acc_sum      = ACC_W'(sat_add(MAX_W'(acc_q), MAX_W'(beat_sum), ACC_W));
    assign acc_carry    = sat_carry(MAX_W'(acc_q), MAX_W'(beat_sum), ACC_W);

    isqrt_seq #(
        .W (ACC_W)
    ) u_isqrt (
        .clock    (clock),
        .reset_n  (reset_n),
        .start_i  (sq_start),
        .op_i     (acc_sum),
        .busy_o   (sq_busy),
        .done_c_o (sq_done_c),
        .root_o   (sq_root)
    );

    // Accumulator, engine FSM and output register next-state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        eng_sum_d   = eng_sum_q;
        eng_mode_d  = eng_mode_q;
        eng_ovf_d   = eng_ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        sq_start    = 1'b0;
        xfer        = 1'b0;

        if (in_accept) begin
            if (io_in_tlast) begin
                acc_d      = '0;
                ovf_d      = 1'b0;
                eng_sum_d  = acc_sum;
                eng_mode_d = io_mode;
                eng_ovf_d  = ovf_q | acc_carry;
            end else begin
                acc_d = acc_sum;
                ovf_d = ovf_q | acc_carry;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_accept && io_in_tlast) begin
                    if (io_mode) begin
                        state_d = DONE;
                    end else begin
                        state_d  = CALC;
                        sq_start = 1'b1;
                    end
                end
            end
            CALC: begin
                if (sq_busy && sq_done_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q || io_out_tready) begin
                    xfer    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = eng_mode_q ? eng_sum_q : ACC_W'(sq_root);
            out_user_d  = eng_ovf_q;
        end else if (io_out_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            eng_sum_q   <= '0;
            eng_mode_q  <= 1'b0;
            eng_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            eng_sum_q   <= eng_sum_d;
            eng_mode_q  <= eng_mode_d;
            eng_ovf_q   <= eng_ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
        end
    end

    assign io_out_tdata  = out_data_q;
    assign io_out_tvalid = out_valid_q;
    assign io_out_tuser  = out_user_q;
    assign io_out_tkeep  = '1;
    assign io_out_tlast  = out_valid_q;

endmodule

// File: tb/tb_l2_norm_axis_param.sv
// Directed and random checks of l2_norm_axis_param against a plain-arithmetic model,
// using a 32-bit instance (a_*) and a 16-bit saturation instance (b_*).
module tb_l2_norm_axis_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic [63:0] a_tdata,  b_tdata;
    logic        a_tvalid, b_tvalid;
    logic [7:0]  a_tkeep,  b_tkeep;
    logic        a_tlast,  b_tlast;
    logic        a_tready, b_tready;
    logic        a_mode,   b_mode;
    logic [31:0] a_out_tdata;
    logic [15:0] b_out_tdata;
    logic        a_out_tvalid, b_out_tvalid;
    logic        a_out_tuser,  b_out_tuser;
    logic [3:0]  a_out_tkeep;
    logic [1:0]  b_out_tkeep;
    logic        a_out_tlast,  b_out_tlast;
    logic        a_out_tready, b_out_tready;

    l2_norm_axis_param u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .io_in_tdata(a_tdata), .io_in_tvalid(a_tvalid), .io_in_tkeep(a_tkeep),
        .io_in_tlast(a_tlast), .io_in_tready(a_tready), .io_mode(a_mode),
        .io_out_tdata(a_out_tdata), .io_out_tvalid(a_out_tvalid), .io_out_tuser(a_out_tuser),
        .io_out_tkeep(a_out_tkeep), .io_out_tlast(a_out_tlast), .io_out_tready(a_out_tready)
    );

    l2_norm_axis_param #(.ACC_W(16)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .io_in_tdata(b_tdata), .io_in_tvalid(b_tvalid), .io_in_tkeep(b_tkeep),
        .io_in_tlast(b_tlast), .io_in_tready(b_tready), .io_mode(b_mode),
        .io_out_tdata(b_out_tdata), .io_out_tvalid(b_out_tvalid), .io_out_tuser(b_out_tuser),
        .io_out_tkeep(b_out_tkeep), .io_out_tlast(b_out_tlast), .io_out_tready(b_out_tready)
    );

    int n_vec = 0;
    int n_mis = 0;
    logic [63:0] vd[$];
    logic [7:0]  vk[$];
    logic [31:0] mon_d[$];
    logic        mon_u[$];

    // Transfers on the 32-bit output, observed the half cycle before the edge that takes them.
    always @(negedge clock) begin
        if (reset_n && a_out_tvalid && a_out_tready) begin
            mon_d.push_back(a_out_tdata);
            mon_u.push_back(a_out_tuser);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint beat_model(input logic [63:0] d, input logic [7:0] k);
        longint s = 0;
        for (int i = 0; i < 8; i++) begin
            longint e;
            e = longint'($signed(d[i*8 +: 8]));
            if (k[i]) s += e * e;
        end
        return s;
    endfunction

    function automatic longint isqrt_model(input longint s);
        longint r;
        r = longint'($floor($sqrt(real'(s))));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic drive(input bit sel, input logic [63:0] d, input logic [7:0] k,
                         input logic v, input logic l, input logic m);
        if (sel) begin
            b_tdata = d; b_tkeep = k; b_tvalid = v; b_tlast = l; b_mode = m;
        end else begin
            a_tdata = d; a_tkeep = k; a_tvalid = v; a_tlast = l; a_mode = m;
        end
    endtask

    task automatic wait_accept(input bit sel, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < 300) begin
            @(negedge clock);
            if (sel ? b_tready : a_tready) ok = 1'b1;
            else waited++;
        end
        @(posedge clock); #1;
        drive(sel, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_vec(input bit sel, input logic m, input string tag,
                            output longint exp_d, output logic exp_u, output int last_wait);
        longint total = 0;
        longint maxv;
        bit ok;
        int w;
        maxv = (longint'(1) << (sel ? 16 : 32)) - 1;
        last_wait = 0;
        foreach (vd[i]) begin
            total += beat_model(vd[i], vk[i]);
            drive(sel, vd[i], vk[i], 1'b1, i == vd.size() - 1, m);
            wait_accept(sel, ok, w);
            check({tag, "_accept"}, 64'(ok), 64'd1);
            last_wait = w;
        end
        exp_u = total > maxv;
        if (exp_u) total = maxv;
        exp_d = m ? total : isqrt_model(total);
    endtask

    task automatic expect_result(input bit sel, input string tag, input longint exp_d,
                                 input logic exp_u, input int exp_lat);
        int n = 0;
        while (!(sel ? b_out_tvalid : a_out_tvalid) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_valid"}, 64'(sel ? b_out_tvalid : a_out_tvalid), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_data"}, sel ? 64'(b_out_tdata) : 64'(a_out_tdata), 64'(exp_d));
        check({tag, "_user"}, 64'(sel ? b_out_tuser : a_out_tuser), 64'(exp_u));
        check({tag, "_tlast"}, 64'(sel ? b_out_tlast : a_out_tlast), 64'd1);
    endtask

    task automatic set_vec1(input logic [63:0] d, input logic [7:0] k);
        vd.delete(); vk.delete();
        vd.push_back(d); vk.push_back(k);
    endtask

    localparam logic [63:0] ALL3   = 64'h0303_0303_0303_0303;
    localparam logic [63:0] ALLM   = 64'h8080_8080_8080_8080;
    localparam logic [63:0] MIXED  = 64'h6464_6464_0505_0505;
    localparam logic [63:0] ALL64  = 64'h4040_4040_4040_4040;
    localparam logic [63:0] ALL1   = 64'h0101_0101_0101_0101;
    localparam logic [63:0] ALL100 = 64'h6464_6464_6464_6464;

    initial begin
        longint ed;
        logic eu;
        int lw;
        bit ok;
        int w;
        int bad_rdy;
        int bad_data;
        int n;

        drive(1'b0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        a_out_tready = 1'b1;
        b_out_tready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 64'(a_out_tvalid), 64'd0);
        check("rst_data", 64'(a_out_tdata), 64'd0);
        check("rst_user", 64'(a_out_tuser), 64'd0);
        check("rst_tlast", 64'(a_out_tlast), 64'd0);
        check("rst_tkeep_a", 64'(a_out_tkeep), 64'hF);
        check("rst_tkeep_b", 64'(b_out_tkeep), 64'h3);
        check("rst_in_ready", 64'(a_tready), 64'd1);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        set_vec1(ALL3, 8'hFF);
        send_vec(1'b0, 1'b0, "all3", ed, eu, lw);
        check("all3_model", 64'(ed), 64'd8);
        expect_result(1'b0, "all3", ed, eu, 17);

        vd.delete(); vk.delete();
        vd.push_back(ALLM); vk.push_back(8'hFF);
        vd.push_back(ALLM); vk.push_back(8'hFF);
        send_vec(1'b0, 1'b0, "neg_sqrt", ed, eu, lw);
        expect_result(1'b0, "neg_sqrt", ed, eu, 17);
        send_vec(1'b0, 1'b1, "neg_raw", ed, eu, lw);
        check("neg_raw_model", 64'(ed), 64'd262144);
        expect_result(1'b0, "neg_raw", ed, eu, 1);

        set_vec1(MIXED, 8'h0F);
        send_vec(1'b0, 1'b0, "keep0f", ed, eu, lw);
        expect_result(1'b0, "keep0f", ed, eu, 17);
        set_vec1(ALL100, 8'h00);
        send_vec(1'b0, 1'b0, "keep00", ed, eu, lw);
        expect_result(1'b0, "keep00", ed, eu, 17);

        for (int t = 0; t < 24; t++) begin
            logic m;
            vd.delete(); vk.delete();
            for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                vd.push_back({$urandom, $urandom});
                vk.push_back(8'($urandom_range(0, 255)));
            end
            m = 1'($urandom_range(0, 1));
            send_vec(1'b0, m, "rand", ed, eu, lw);
            expect_result(1'b0, "rand", ed, eu, m ? 1 : 17);
        end

        // Backpressure: three vectors queue up behind a stalled output.
        @(posedge clock); #1;
        mon_d.delete(); mon_u.delete();
        a_out_tready = 1'b0;
        set_vec1(ALL3, 8'hFF);
        send_vec(1'b0, 1'b0, "bp1", ed, eu, lw);
        expect_result(1'b0, "bp1", ed, eu, 17);
        set_vec1(MIXED, 8'h0F);
        send_vec(1'b0, 1'b0, "bp2", ed, eu, lw);
        check("bp2_tlast_wait", 64'(lw), 64'd0);
        repeat (25) @(posedge clock);
        #1;
        drive(1'b0, ALLM, 8'hFF, 1'b1, 1'b0, 1'b0);
        wait_accept(1'b0, ok, w);
        check("bp3_first_wait", 64'(w), 64'd0);
        drive(1'b0, ALLM, 8'hFF, 1'b1, 1'b1, 1'b0);
        bad_rdy = 0;
        bad_data = 0;
        repeat (20) begin
            @(negedge clock);
            if (a_tready !== 1'b0) bad_rdy++;
            if (a_out_tdata !== 32'd8 || a_out_tvalid !== 1'b1) bad_data++;
        end
        check("bp3_tlast_stalled", 64'(bad_rdy), 64'd0);
        check("bp_out_stable", 64'(bad_data), 64'd0);
        @(posedge clock); #1;
        a_out_tready = 1'b1;
        wait_accept(1'b0, ok, w);
        check("bp3_accept", 64'(ok), 64'd1);
        n = 0;
        while (mon_d.size() < 3 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("bp_count", 64'(mon_d.size()), 64'd3);
        if (mon_d.size() >= 3) begin
            check("bp_res0", 64'(mon_d[0]), 64'd8);
            check("bp_res1", 64'(mon_d[1]), 64'd10);
            check("bp_res2", 64'(mon_d[2]), 64'd512);
            check("bp_user", 64'({mon_u[0], mon_u[1], mon_u[2]}), 64'd0);
        end

        // 16-bit accumulator saturation and recovery.
        vd.delete(); vk.delete();
        vd.push_back(ALL64); vk.push_back(8'hFF);
        vd.push_back(ALL64); vk.push_back(8'hFF);
        vd.push_back(ALL1);  vk.push_back(8'hFF);
        send_vec(1'b1, 1'b1, "sat_raw", ed, eu, lw);
        check("sat_raw_model", 64'(ed), 64'd65535);
        expect_result(1'b1, "sat_raw", ed, eu, 1);
        set_vec1(ALL3, 8'hFF);
        send_vec(1'b1, 1'b1, "after_sat", ed, eu, lw);
        expect_result(1'b1, "after_sat", ed, eu, 1);
        set_vec1(ALLM, 8'hFF);
        send_vec(1'b1, 1'b0, "sat_sqrt", ed, eu, lw);
        expect_result(1'b1, "sat_sqrt", ed, eu, 9);
        set_vec1(ALL3, 8'hFF);
        send_vec(1'b1, 1'b0, "b_all3", ed, eu, lw);
        expect_result(1'b1, "b_all3", ed, eu, 9);

        // Asynchronous reset mid-CALC and mid-accumulation.
        @(posedge clock); #1;
        a_out_tready = 1'b0;
        set_vec1(ALL3, 8'hFF);
        send_vec(1'b0, 1'b1, "pre_rst", ed, eu, lw);
        expect_result(1'b0, "pre_rst", ed, eu, 1);
        send_vec(1'b0, 1'b0, "calc_rst", ed, eu, lw);
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_calc_valid", 64'(a_out_tvalid), 64'd0);
        check("rst_calc_data", 64'(a_out_tdata), 64'd0);
        check("rst_calc_ready", 64'(a_tready), 64'd1);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        drive(1'b0, ALL100, 8'hFF, 1'b1, 1'b0, 1'b0);
        wait_accept(1'b0, ok, w);
        check("acc_beat_accept", 64'(ok), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_acc_valid", 64'(a_out_tvalid), 64'd0);
        @(negedge clock) reset_n = 1'b1;
        a_out_tready = 1'b1;
        @(posedge clock); #1;
        set_vec1(ALL3, 8'hFF);
        send_vec(1'b0, 1'b0, "post_rst", ed, eu, lw);
        expect_result(1'b0, "post_rst", 64'd8, 1'b0, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
